// File: rtl/wb_cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC/BadVAddr/Count/Compare plus exception/eret commit.
// Latency: cp0_rdata and flush/flush_pc are combinational; register updates land on the next clk edge.
// Backpressure: none; one writeback per cycle is always accepted, and flush is a one-cycle pulse per event.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   wb_valid/pc/bd     : committing instruction, its PC, and delay-slot flag
//   wb_exc/exccode     : exception flagged upstream and its code
//   wb_badvaddr        : faulting address, captured for AdEL/AdES only
//   wb_eret            : committing instruction is an eret
//   mtc0_we/cp0_addr/  : CP0 register write ({rd, sel} address), qualified by wb_valid
//   cp0_wdata
//   cp0_rdata          : combinational read of cp0_addr
//   hw_int             : level-sensitive hardware interrupt lines
//   flush/flush_pc     : pipeline redirect to exception vector or EPC
module wb_cp0_exc_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [31:0]           wb_pc,
  input  logic                  wb_bd,
  input  logic                  wb_exc,
  input  logic [4:0]            wb_exccode,
  input  logic [31:0]           wb_badvaddr,
  input  logic                  wb_eret,
  input  logic                  mtc0_we,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           cp0_wdata,
  output logic [31:0]           cp0_rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  flush,
  output logic [31:0]           flush_pc
);

  // CP0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  // Divider width stays at least one bit so COUNT_DIV=1 still elaborates.
  localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  // Status fields
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;

  // Cause fields
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;   // IP[7:2]
  logic [1:0]  cause_ip_sw;   // IP[1:0]
  logic [4:0]  cause_exccode;

  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [DIV_W-1:0] div_cnt;

  // Combinational control
  logic [5:0]  hw_ext;
  logic [5:0]  ip_hw_next;
  logic [7:0]  cause_ip;
  logic        int_req;
  logic        take_exc;
  logic        take_eret;
  logic [4:0]  exc_code;
  logic [31:0] epc_target;
  logic        mtc0_ok;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;

  // Unused hardware lines read as 0; the timer shares IP[7] with hw_int[5].
  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HW_INT-1:0] = hw_int;
    ip_hw_next = {cause_ti | hw_ext[5], hw_ext[4:0]};
  end

  assign cause_ip = {cause_ip_hw, cause_ip_sw};
  assign int_req  = status_ie & ~status_exl & (|(cause_ip & status_im));

  // Interrupts outrank a synchronous exception on the same instruction.
  assign take_exc   = wb_valid & (int_req | wb_exc);
  assign take_eret  = wb_valid & wb_eret & ~take_exc;
  assign exc_code   = int_req ? CODE_INT : wb_exccode;
  assign epc_target = wb_bd ? (wb_pc - 32'd4) : wb_pc;

  // An instruction that traps must not leave a CP0 side effect behind.
  assign mtc0_ok    = wb_valid & mtc0_we & ~take_exc;
  assign wr_status  = mtc0_ok & (cp0_addr == ADDR_STATUS);
  assign wr_cause   = mtc0_ok & (cp0_addr == ADDR_CAUSE);
  assign wr_epc     = mtc0_ok & (cp0_addr == ADDR_EPC);
  assign wr_count   = mtc0_ok & (cp0_addr == ADDR_COUNT);
  assign wr_compare = mtc0_ok & (cp0_addr == ADDR_COMPARE);

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im     <= '0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      cause_ip_hw   <= '0;
      cause_ip_sw   <= '0;
      cause_exccode <= '0;
      epc           <= '0;
      badvaddr      <= '0;
      count         <= '0;
      compare       <= '0;
      div_cnt       <= '0;
    end else begin
      cause_ip_hw <= ip_hw_next;

      // A Count write restarts the divider so the new value holds a full period.
      if (wr_count) begin
        count   <= cp0_wdata;
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        count   <= count + 32'd1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // Writing Compare acknowledges the timer, even against a same-cycle match.
      if (wr_compare) begin
        compare  <= cp0_wdata;
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end

      if (wr_status) begin
        status_im  <= cp0_wdata[15:8];
        status_exl <= cp0_wdata[1];
        status_ie  <= cp0_wdata[0];
      end

      if (wr_cause) begin
        cause_ip_sw <= cp0_wdata[9:8];
      end

      if (wr_epc) begin
        epc <= cp0_wdata;
      end

      if (take_exc) begin
        status_exl    <= 1'b1;
        cause_exccode <= exc_code;
        // A nested exception keeps the original return point.
        if (!status_exl) begin
          epc      <= epc_target;
          cause_bd <= wb_bd;
        end
        if ((exc_code == CODE_ADEL) || (exc_code == CODE_ADES)) begin
          badvaddr <= wb_badvaddr;
        end
      end else if (take_eret) begin
        status_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
      ADDR_CAUSE:    cp0_rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
      ADDR_EPC:      cp0_rdata = epc;
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      default:       cp0_rdata = '0;
    endcase
  end

  // Redirect uses the EPC value held before this edge, so an eret sees the stored return address.
  always_comb begin
    flush    = 1'b0;
    flush_pc = '0;
    if (!reset) begin
      if (take_exc) begin
        flush    = 1'b1;
        flush_pc = EXC_VEC;
      end else if (take_eret) begin
        flush    = 1'b1;
        flush_pc = epc;
      end
    end
  end

endmodule

// File: tb/tb_wb_cp0_exc_ctrl.sv
module tb_wb_cp0_exc_ctrl;

  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;
  localparam logic [7:0] A_UNMAPPED = 8'h61;
  localparam logic [31:0] VEC       = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic        wb_exc;
  logic [4:0]  wb_exccode;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [5:0]  hw_int;
  logic        flush;
  logic [31:0] flush_pc;

  int tests_run = 0;
  int tests_failed = 0;

  wb_cp0_exc_ctrl #(
    .NUM_HW_INT(6),
    .COUNT_DIV (2),
    .EXC_VEC   (VEC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .wb_bd      (wb_bd),
    .wb_exc     (wb_exc),
    .wb_exccode (wb_exccode),
    .wb_badvaddr(wb_badvaddr),
    .wb_eret    (wb_eret),
    .mtc0_we    (mtc0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .hw_int     (hw_int),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid    = 1'b0;
    wb_pc       = '0;
    wb_bd       = 1'b0;
    wb_exc      = 1'b0;
    wb_exccode  = '0;
    wb_badvaddr = '0;
    wb_eret     = 1'b0;
    mtc0_we     = 1'b0;
    cp0_wdata   = '0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_valid  = 1'b1;
    mtc0_we   = 1'b1;
    cp0_addr  = addr;
    cp0_wdata = data;
    step();
    idle();
  endtask

  // One committing instruction that is expected to redirect the pipeline.
  task automatic commit(input string tag, input logic exc, input logic [4:0] code,
                        input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                        input logic eret, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_pc);
    @(negedge clk);
    wb_valid    = 1'b1;
    wb_exc      = exc;
    wb_exccode  = code;
    wb_pc       = pc;
    wb_bd       = bd;
    wb_badvaddr = bva;
    wb_eret     = eret;
    mtc0_we     = we;
    cp0_addr    = addr;
    cp0_wdata   = wdata;
    #1;
    chk({tag, "_flush"}, {31'd0, flush}, 32'd1);
    chk({tag, "_flush_pc"}, flush_pc, exp_pc);
    step();
    idle();
    #1;
    chk({tag, "_pulse"}, {31'd0, flush}, 32'd0);
  endtask

  initial begin
    idle();
    hw_int   = '0;
    cp0_addr = '0;

    // Reset with a trapping instruction and an mtc0 present: both must be ignored.
    reset       = 1'b1;
    wb_valid    = 1'b1;
    wb_exc      = 1'b1;
    wb_exccode  = 5'd8;
    mtc0_we     = 1'b1;
    cp0_addr    = A_EPC;
    cp0_wdata   = 32'h0000DEAD;
    #1;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    step();
    step();
    reset = 1'b0;
    idle();
    rd("rst_status", A_STATUS, 32'h00400000);
    rd("rst_cause", A_CAUSE, 32'h00000000);
    rd("rst_epc", A_EPC, 32'h00000000);

    // Count==Compare==0 here, so this write also checks that clear beats set.
    mtc0(A_COMPARE, 32'h00001000);
    rd("compare_wr", A_COMPARE, 32'h00001000);
    step();
    rd("ti_clear_wins", A_CAUSE, 32'h00000000);

    // Unmapped address: reads 0, write has no effect.
    mtc0(A_UNMAPPED, 32'hFFFFFFFF);
    rd("unmapped_rd", A_UNMAPPED, 32'h00000000);
    rd("unmapped_status", A_STATUS, 32'h00400000);

    // wb_valid=0 masks exc, eret and mtc0.
    @(negedge clk);
    wb_exc    = 1'b1;
    wb_eret   = 1'b1;
    mtc0_we   = 1'b1;
    cp0_addr  = A_COMPARE;
    cp0_wdata = 32'h00000007;
    #1;
    chk("novalid_flush", {31'd0, flush}, 32'd0);
    step();
    idle();
    rd("novalid_compare", A_COMPARE, 32'h00001000);

    // Syscall outside a delay slot.
    commit("sys", 1'b1, 5'd8, 32'hBFC00100, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, A_EPC, 32'd0, VEC);
    rd("sys_epc", A_EPC, 32'hBFC00100);
    rd("sys_cause", A_CAUSE, 32'h00000020);
    rd("sys_status", A_STATUS, 32'h00400002);
    rd("sys_badvaddr", A_BADVADDR, 32'h00000000);

    // Nested AdEL while EXL=1: EPC/BD kept, BadVAddr captured.
    commit("nest", 1'b1, 5'd4, 32'h80000040, 1'b1, 32'h00001235, 1'b0, 1'b0, A_EPC, 32'd0, VEC);
    rd("nest_epc", A_EPC, 32'hBFC00100);
    rd("nest_badvaddr", A_BADVADDR, 32'h00001235);
    rd("nest_cause", A_CAUSE, 32'h00000010);

    // Eret returns to EPC and clears EXL.
    mtc0(A_EPC, 32'h80001000);
    commit("eret", 1'b0, 5'd0, 32'h80000300, 1'b0, 32'd0, 1'b1, 1'b0, A_EPC, 32'd0, 32'h80001000);
    rd("eret_status", A_STATUS, 32'h00400000);

    // Delay-slot exception: EPC points at the branch.
    commit("ds", 1'b1, 5'd8, 32'h80000010, 1'b1, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0, VEC);
    rd("ds_epc", A_EPC, 32'h8000000C);
    rd("ds_cause", A_CAUSE, 32'h80000020);
    commit("ds_eret", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b0, A_EPC, 32'd0, 32'h8000000C);

    // Interrupt beats a same-cycle Reserved-Instruction and suppresses the mtc0.
    mtc0(A_STATUS, 32'h00000401);
    rd("pri_status_wr", A_STATUS, 32'h00400401);
    hw_int = 6'b000001;
    step();
    rd("pri_ip", A_CAUSE, 32'h80000420);
    commit("pri", 1'b1, 5'd10, 32'h80000100, 1'b0, 32'd0, 1'b0, 1'b1, A_EPC, 32'h12345678, VEC);
    rd("pri_epc", A_EPC, 32'h80000100);
    rd("pri_cause", A_CAUSE, 32'h00000400);
    rd("pri_status", A_STATUS, 32'h00400403);
    hw_int = '0;
    commit("pri_eret", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b0, A_EPC, 32'd0, 32'h80000100);

    // Timer: Count advances every 2 cycles, TI one cycle after the match, IP[7] one after that.
    mtc0(A_COUNT, 32'h00000100);
    mtc0(A_COMPARE, 32'h00000005);
    mtc0(A_STATUS, 32'h00008001);
    rd("tmr_status", A_STATUS, 32'h00408001);
    mtc0(A_COUNT, 32'h00000000);
    rd("tmr_cnt_e0", A_COUNT, 32'd0);
    step();
    rd("tmr_cnt_e1", A_COUNT, 32'd0);
    step();
    rd("tmr_cnt_e2", A_COUNT, 32'd1);
    for (int i = 0; i < 8; i++) step();
    rd("tmr_cnt_e10", A_COUNT, 32'd5);
    rd("tmr_ti_pre", A_CAUSE, 32'h00000000);
    step();
    rd("tmr_ti_set", A_CAUSE, 32'h40000000);
    step();
    rd("tmr_ip7", A_CAUSE, 32'h40008000);
    commit("tmr", 1'b0, 5'd0, 32'h80000200, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0, VEC);
    rd("tmr_cause", A_CAUSE, 32'h40008000);
    rd("tmr_epc", A_EPC, 32'h80000200);
    rd("tmr_exl", A_STATUS, 32'h00408003);
    mtc0(A_COMPARE, 32'h00000100);
    rd("tmr_ti_clr", A_CAUSE, 32'h00008000);

    // Count wraps to zero.
    mtc0(A_COUNT, 32'hFFFFFFFF);
    rd("wrap_e0", A_COUNT, 32'hFFFFFFFF);
    step();
    rd("wrap_e1", A_COUNT, 32'hFFFFFFFF);
    step();
    rd("wrap_e2", A_COUNT, 32'h00000000);

    // Reset mid-count beats a same-cycle exception and mtc0.
    @(negedge clk);
    reset       = 1'b1;
    wb_valid    = 1'b1;
    wb_exc      = 1'b1;
    wb_exccode  = 5'd8;
    wb_pc       = 32'h80000400;
    mtc0_we     = 1'b1;
    cp0_addr    = A_COUNT;
    cp0_wdata   = 32'h00000055;
    #1;
    chk("rst2_flush", {31'd0, flush}, 32'd0);
    chk("rst2_flush_pc", flush_pc, 32'd0);
    step();
    reset = 1'b0;
    idle();
    rd("rst2_count", A_COUNT, 32'd0);
    rd("rst2_status", A_STATUS, 32'h00400000);
    rd("rst2_epc", A_EPC, 32'd0);
    rd("rst2_compare", A_COMPARE, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
